// File: rtl/neighbor_count_engine.sv
// rtl/neighbor_count_engine.sv - adjacent-mine counter for one board tile
// Walks centre then NW..SE through the 1-bit mine map; returns 0-8, 9 (mine) or 15 (off-board).
module neighbor_count_engine #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int RW     = $clog2(ROWS),
  parameter int CW     = $clog2(COLS),
  parameter int ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [RW-1:0]     row_i,
  input  logic [CW-1:0]     col_i,
  output logic              busy_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_data_i,
  output logic [3:0]        count_o,
  output logic              is_mine_o,
  output logic              count_valid_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LAST = 2'd2} state_t;

  localparam logic [RW:0]          ROWS_U = (RW+1)'(ROWS);
  localparam logic [CW:0]          COLS_U = (CW+1)'(COLS);
  localparam logic signed [RW+1:0] ROWS_S = (RW+2)'(ROWS);
  localparam logic signed [CW+1:0] COLS_S = (CW+2)'(COLS);

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                oor_q, oor_d;
  logic [3:0]          k_q, k_d;
  logic                busy_q, busy_d;
  logic                rd_q, rd_d, rdc_q, rdc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pend_q, pend_d, pend_c_q, pend_c_d;
  logic [3:0]          acc_q, acc_d;
  logic                mine_q, mine_d;
  logic [3:0]          count_q, count_d;
  logic                is_mine_q, is_mine_d;
  logic                valid_q, valid_d;

  logic                req_oor, pos_oor, pos_in, issue, mine_nx;
  logic [RW-1:0]       base_r;
  logic [CW-1:0]       base_c;
  logic [3:0]          pos_k, acc_nx;
  logic signed [1:0]   dr, dc;
  logic signed [RW+1:0] nr;
  logic signed [CW+1:0] nc;
  logic [ADDR_W-1:0]   pos_addr;

  assign req_oor = ({1'b0, row_i} >= ROWS_U) || ({1'b0, col_i} >= COLS_U);

  // The centre read is issued straight from the request inputs on the accepting edge.
  always_comb begin
    base_r  = row_q;
    base_c  = col_q;
    pos_k   = k_q + 4'd1;
    pos_oor = oor_q;
    if (state_q == IDLE) begin
      base_r  = row_i;
      base_c  = col_i;
      pos_k   = 4'd0;
      pos_oor = req_oor;
    end
    dr = 2'sd0;
    dc = 2'sd0;
    case (pos_k)
      4'd1: begin dr = -2'sd1; dc = -2'sd1; end
      4'd2: begin dr = -2'sd1; dc =  2'sd0; end
      4'd3: begin dr = -2'sd1; dc =  2'sd1; end
      4'd4: begin dr =  2'sd0; dc = -2'sd1; end
      4'd5: begin dr =  2'sd0; dc =  2'sd1; end
      4'd6: begin dr =  2'sd1; dc = -2'sd1; end
      4'd7: begin dr =  2'sd1; dc =  2'sd0; end
      4'd8: begin dr =  2'sd1; dc =  2'sd1; end
      default: ;
    endcase
    nr = $signed({2'b00, base_r}) + (RW+2)'(dr);
    nc = $signed({2'b00, base_c}) + (CW+2)'(dc);
    pos_in = !pos_oor && !nr[RW+1] && (nr < ROWS_S) && !nc[CW+1] && (nc < COLS_S);
    pos_addr = ADDR_W'(nr[RW-1:0]) * ADDR_W'(COLS) + ADDR_W'(nc[CW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SCAN;
      SCAN:    if (k_q == 4'd8) state_d = LAST;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    oor_d     = oor_q;
    k_d       = k_q;
    busy_d    = busy_q;
    rd_d      = 1'b0;
    rdc_d     = 1'b0;
    addr_d    = addr_q;
    pend_d    = rd_q;
    pend_c_d  = rdc_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    is_mine_d = is_mine_q;
    issue     = 1'b0;
    // Read data lands one cycle after its strobe, hence the pend pipeline stage.
    mine_nx   = mine_q | (pend_q & pend_c_q & mem_data_i);
    acc_nx    = acc_q + 4'(pend_q & ~pend_c_q & mem_data_i);
    mine_d    = mine_nx;
    acc_d     = acc_nx;
    case (state_q)
      IDLE: begin
        if (valid_q) busy_d = 1'b0;
        if (start_i) begin
          row_d  = row_i;
          col_d  = col_i;
          oor_d  = req_oor;
          busy_d = 1'b1;
          k_d    = 4'd0;
          acc_d  = 4'd0;
          mine_d = 1'b0;
          issue  = 1'b1;
        end
      end
      SCAN: begin
        if (k_q != 4'd8) begin
          k_d   = k_q + 4'd1;
          issue = 1'b1;
        end
      end
      LAST: begin
        valid_d   = 1'b1;
        count_d   = oor_q ? 4'd15 : (mine_nx ? 4'd9 : acc_nx);
        is_mine_d = mine_nx & ~oor_q;
      end
      default: ;
    endcase
    if (issue && pos_in) begin
      rd_d   = 1'b1;
      rdc_d  = (pos_k == 4'd0);
      addr_d = pos_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      oor_q     <= 1'b0;
      k_q       <= 4'd0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      rdc_q     <= 1'b0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      pend_c_q  <= 1'b0;
      acc_q     <= 4'd0;
      mine_q    <= 1'b0;
      count_q   <= 4'd0;
      is_mine_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      oor_q     <= oor_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      rd_q      <= rd_d;
      rdc_q     <= rdc_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      pend_c_q  <= pend_c_d;
      acc_q     <= acc_d;
      mine_q    <= mine_d;
      count_q   <= count_d;
      is_mine_q <= is_mine_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o        = busy_q;
  assign mem_rd_o      = rd_q;
  assign mem_addr_o    = addr_q;
  assign count_o       = count_q;
  assign is_mine_o     = is_mine_q;
  assign count_valid_o = valid_q;

endmodule

// File: tb/tb_neighbor_count_engine.sv
// tb/tb_neighbor_count_engine.sv - directed bench for neighbor_count_engine
// A 16x16 instance plus a 10x12 instance sharing the request inputs for off-board requests.
module tb_neighbor_count_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] row = '0, col = '0;

  logic       busy1, rd1, data1, mine1, valid1;
  logic [7:0] addr1;
  logic [3:0] cnt1;
  logic       busy2, rd2, data2, mine2, valid2;
  logic [6:0] addr2;
  logic [3:0] cnt2;

  logic [255:0] map1 = '0;
  logic [119:0] map2 = '0;

  int checks = 0, errors = 0;
  int rd_total = 0, rd_total2 = 0, vcnt1 = 0, vcnt2 = 0;
  int rd_log [0:1023];

  always #5 clk = ~clk;

  neighbor_count_engine #(.ROWS(16), .COLS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .row_i(row), .col_i(col),
    .busy_o(busy1), .mem_rd_o(rd1), .mem_addr_o(addr1), .mem_data_i(data1),
    .count_o(cnt1), .is_mine_o(mine1), .count_valid_o(valid1));

  neighbor_count_engine #(.ROWS(10), .COLS(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .row_i(row), .col_i(col),
    .busy_o(busy2), .mem_rd_o(rd2), .mem_addr_o(addr2), .mem_data_i(data2),
    .count_o(cnt2), .is_mine_o(mine2), .count_valid_o(valid2));

  always @(posedge clk) begin
    data1 <= rd1 ? map1[addr1] : 1'b0;
    data2 <= rd2 ? map2[addr2] : 1'b0;
  end

  always @(posedge clk) begin
    if (rd1) begin
      if (rd_total < 1024) rd_log[rd_total] = int'(addr1);
      rd_total++;
    end
    if (rd2) rd_total2++;
    if (valid1) vcnt1++;
    if (valid2) vcnt2++;
  end

  task automatic run_tile(input logic [3:0] r, input logic [3:0] c, input bit which,
                          output int lat, output logic [3:0] cnt, output logic mine,
                          output logic busy_e0, output logic busy_end);
    @(negedge clk);
    row = r; col = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_e0 = which ? busy2 : busy1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((which ? valid2 : valid1) === 1'b1) begin
        lat = n;
        break;
      end
    end
    cnt  = which ? cnt2 : cnt1;
    mine = which ? mine2 : mine1;
    @(negedge clk);
    busy_end = which ? busy2 : busy1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
    if (rd1 !== 1'b0)     begin errors++; $display("FAIL reset_mem_rd got %b exp 0", rd1); end
    if (addr1 !== 8'd0)   begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", addr1); end
    if (cnt1 !== 4'd0)    begin errors++; $display("FAIL reset_count got %0d exp 0", cnt1); end
    if (mine1 !== 1'b0)   begin errors++; $display("FAIL reset_is_mine got %b exp 0", mine1); end
    if (valid1 !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", valid1); end
    rst_n = 1'b1;
  endtask

  task automatic test_interior;
    int lat, base;
    logic [3:0] cnt;
    logic mine, be0, bend;
    map1 = '0; map1[68] = 1'b1; map1[70] = 1'b1; map1[101] = 1'b1;
    base = rd_total;
    run_tile(4'd5, 4'd5, 1'b0, lat, cnt, mine, be0, bend);
    checks += 8;
    if (lat != 10)      begin errors++; $display("FAIL interior_latency got %0d exp 10", lat); end
    if (cnt !== 4'd3)   begin errors++; $display("FAIL interior_count got %0d exp 3", cnt); end
    if (mine !== 1'b0)  begin errors++; $display("FAIL interior_is_mine got %b exp 0", mine); end
    if (be0 !== 1'b1)   begin errors++; $display("FAIL interior_busy_e0 got %b exp 1", be0); end
    if (bend !== 1'b0)  begin errors++; $display("FAIL interior_busy_e11 got %b exp 0", bend); end
    if (rd_total - base != 9) begin errors++; $display("FAIL interior_reads got %0d exp 9", rd_total - base); end
    if (rd_log[base] != 85)   begin errors++; $display("FAIL interior_first_addr got %0d exp 85", rd_log[base]); end
    if (rd_log[base+8] != 102) begin errors++; $display("FAIL interior_last_addr got %0d exp 102", rd_log[base+8]); end
  endtask

  task automatic test_corner;
    int lat, base;
    int exp_a [4];
    logic [3:0] cnt;
    logic mine, be0, bend;
    exp_a = '{0, 1, 16, 17};
    map1 = '0; map1[1] = 1'b1; map1[17] = 1'b1;
    base = rd_total;
    run_tile(4'd0, 4'd0, 1'b0, lat, cnt, mine, be0, bend);
    checks += 3;
    if (lat != 10)    begin errors++; $display("FAIL corner_latency got %0d exp 10", lat); end
    if (cnt !== 4'd2) begin errors++; $display("FAIL corner_count got %0d exp 2", cnt); end
    if (rd_total - base != 4) begin errors++; $display("FAIL corner_reads got %0d exp 4", rd_total - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[base+i] != exp_a[i])
        begin errors++; $display("FAIL corner_addr%0d got %0d exp %0d", i, rd_log[base+i], exp_a[i]); end
    end
  endtask

  task automatic test_centre_mine;
    int lat;
    logic [3:0] cnt;
    logic mine, be0, bend;
    map1 = '0; map1[115] = 1'b1; map1[98] = 1'b1; map1[132] = 1'b1;
    run_tile(4'd7, 4'd3, 1'b0, lat, cnt, mine, be0, bend);
    checks += 3;
    if (lat != 10)     begin errors++; $display("FAIL mine_latency got %0d exp 10", lat); end
    if (cnt !== 4'd9)  begin errors++; $display("FAIL mine_count got %0d exp 9", cnt); end
    if (mine !== 1'b1) begin errors++; $display("FAIL mine_is_mine got %b exp 1", mine); end
  endtask

  task automatic test_full_and_empty;
    int lat, vbase, base;
    logic [3:0] cnt;
    logic mine, be0, bend;
    map1 = '0;
    map1[119] = 1'b1; map1[120] = 1'b1; map1[121] = 1'b1; map1[135] = 1'b1;
    map1[137] = 1'b1; map1[151] = 1'b1; map1[152] = 1'b1; map1[153] = 1'b1;
    vbase = vcnt1;
    run_tile(4'd8, 4'd8, 1'b0, lat, cnt, mine, be0, bend);
    checks += 3;
    if (cnt !== 4'd8)  begin errors++; $display("FAIL full_count got %0d exp 8", cnt); end
    if (mine !== 1'b0) begin errors++; $display("FAIL full_is_mine got %b exp 0", mine); end
    if (vcnt1 - vbase != 1) begin errors++; $display("FAIL full_valid_pulses got %0d exp 1", vcnt1 - vbase); end
    map1 = '0;
    base = rd_total;
    run_tile(4'd15, 4'd15, 1'b0, lat, cnt, mine, be0, bend);
    repeat (3) @(negedge clk);
    checks += 4;
    if (cnt !== 4'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", cnt); end
    if (lat != 10)    begin errors++; $display("FAIL empty_latency got %0d exp 10", lat); end
    if (rd_total - base != 4) begin errors++; $display("FAIL empty_reads got %0d exp 4", rd_total - base); end
    if (vcnt1 - vbase != 2) begin errors++; $display("FAIL empty_valid_pulses got %0d exp 2", vcnt1 - vbase); end
  endtask

  task automatic test_back_to_back;
    int vbase;
    bit early;
    map1 = '0; map1[68] = 1'b1; map1[70] = 1'b1; map1[101] = 1'b1; map1[153] = 1'b1;
    vbase = vcnt1;
    early = 1'b0;
    @(negedge clk);
    row = 4'd5; col = 4'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n < 10 && valid1 !== 1'b0) early = 1'b1;
      if (n == 2) begin start = 1'b1; row = 4'd8; col = 4'd0; end
      if (n == 3) begin start = 1'b0; row = 4'd9; end
      if (n == 10) begin
        checks += 3;
        if (early)            begin errors++; $display("FAIL b2b_early_valid got 1 exp 0"); end
        if (valid1 !== 1'b1)  begin errors++; $display("FAIL b2b_first_valid got %b exp 1", valid1); end
        if (cnt1 !== 4'd3)    begin errors++; $display("FAIL b2b_first_count got %0d exp 3", cnt1); end
        start = 1'b1; row = 4'd8; col = 4'd8;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_e11_accept got %b exp 1", busy1); end
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      if (m == 10) begin
        checks += 2;
        if (valid1 !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b exp 1", valid1); end
        if (cnt1 !== 4'd1)   begin errors++; $display("FAIL b2b_second_count got %0d exp 1", cnt1); end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (vcnt1 - vbase != 2) begin errors++; $display("FAIL b2b_valid_pulses got %0d exp 2", vcnt1 - vbase); end
  endtask

  task automatic test_reset_abort;
    int vbase, base2, lat;
    logic [3:0] cnt;
    logic mine, be0, bend;
    map1 = '0; map1[68] = 1'b1;
    @(negedge clk);
    row = 4'd5; col = 4'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vbase = vcnt1;
    checks += 6;
    if (busy1 !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b exp 0", busy1); end
    if (rd1 !== 1'b0)    begin errors++; $display("FAIL abort_mem_rd got %b exp 0", rd1); end
    if (addr1 !== 8'd0)  begin errors++; $display("FAIL abort_mem_addr got %0d exp 0", addr1); end
    if (cnt1 !== 4'd0)   begin errors++; $display("FAIL abort_count got %0d exp 0", cnt1); end
    if (mine1 !== 1'b0)  begin errors++; $display("FAIL abort_is_mine got %b exp 0", mine1); end
    if (valid1 !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid1); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (vcnt1 != vbase) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", vcnt1 - vbase); end
    base2 = rd_total2;
    run_tile(4'd12, 4'd3, 1'b1, lat, cnt, mine, be0, bend);
    checks += 4;
    if (lat != 10)     begin errors++; $display("FAIL oor_latency got %0d exp 10", lat); end
    if (cnt !== 4'd15) begin errors++; $display("FAIL oor_count got %0d exp 15", cnt); end
    if (mine !== 1'b0) begin errors++; $display("FAIL oor_is_mine got %b exp 0", mine); end
    if (rd_total2 - base2 != 0) begin errors++; $display("FAIL oor_reads got %0d exp 0", rd_total2 - base2); end
  endtask

  initial begin
    test_reset();
    test_interior();
    test_corner();
    test_centre_mine();
    test_full_and_empty();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
